// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync request path: RF verdict encoding and the
// request record carried between the network, the per-port queue and the RF.
package fractal_sync_pkg;

   localparam int unsigned SYNC_LEVEL_WIDTH = 1;
   localparam int unsigned SYNC_ID_WIDTH    = 1;

   typedef enum logic [2:0] {
      VERD_ERR,
      VERD_IGNORE,
      VERD_BYPASS,
      VERD_PRESENT,
      VERD_RECORD
   } rf_verdict_e;

   typedef struct packed {
      logic [SYNC_LEVEL_WIDTH-1:0] level;
      logic [SYNC_ID_WIDTH-1:0]    id;
   } sync_req_t;

   // Fixed priority: an error always wins, then drop, then recirculate, then completion.
   function automatic rf_verdict_e rf_verdict_decode(input logic err,
                                                     input logic ignore,
                                                     input logic bypass,
                                                     input logic present);
      if (err)          return VERD_ERR;
      else if (ignore)  return VERD_IGNORE;
      else if (bypass)  return VERD_BYPASS;
      else if (present) return VERD_PRESENT;
      else              return VERD_RECORD;
   endfunction

endpackage

// File: rtl/fractal_sync_req_ring.sv
// DEPTH-entry circular buffer with one write and one read port; occupancy is
// tracked by count so full and empty stay distinct when the pointers coincide.
module fractal_sync_req_ring import fractal_sync_pkg::*; #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = sync_req_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   output entry_t                       head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fractal_sync_1d_req_queue.sv
// Per-port request queue in front of fractal_sync_1d_rf: presents the head as a
// local or remote check and applies the RF verdict on the following edge.
module fractal_sync_1d_req_queue import fractal_sync_pkg::*; #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned LEVEL_WIDTH = SYNC_LEVEL_WIDTH,
   parameter int unsigned ID_WIDTH    = SYNC_ID_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic [LEVEL_WIDTH-1:0]       req_level_i,
   input  logic [ID_WIDTH-1:0]          req_id_i,
   output logic [LEVEL_WIDTH-1:0]       level_o,
   output logic [ID_WIDTH-1:0]          id_o,
   output logic                         check_local_o,
   output logic                         check_remote_o,
   input  logic                         present_local_i,
   input  logic                         present_remote_i,
   input  logic                         id_err_i,
   input  logic                         sig_err_i,
   input  logic                         bypass_local_i,
   input  logic                         bypass_remote_i,
   input  logic                         ignore_local_i,
   input  logic                         ignore_remote_i,
   output logic                         done_valid_o,
   input  logic                         done_ready_i,
   output logic [LEVEL_WIDTH-1:0]       done_level_o,
   output logic [ID_WIDTH-1:0]          done_id_o,
   output logic                         err_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   typedef struct packed {
      logic [LEVEL_WIDTH-1:0] level;
      logic [ID_WIDTH-1:0]    id;
   } req_t;

   req_t        head;
   req_t        push_data;
   logic        full;
   logic        empty;
   logic        check;
   logic        head_local;
   logic        bypass;
   logic        push;
   logic        pop;
   rf_verdict_e verdict;

   // Checks are only issued while done_ready_i is high, so a present verdict can
   // always be delivered in the same cycle and every checked head pops.
   assign head_local = (head.level == '0);
   assign check      = !empty && done_ready_i;

   always_comb begin
      verdict = VERD_RECORD;
      if (head_local)
         verdict = rf_verdict_decode(id_err_i, ignore_local_i, bypass_local_i, present_local_i);
      else
         verdict = rf_verdict_decode(sig_err_i, ignore_remote_i, bypass_remote_i, present_remote_i);
   end

   assign pop    = check;
   assign bypass = check && (verdict == VERD_BYPASS);

   // Handshake: a request transfers on any posedge where req_valid_i && req_ready_o.
   // A bypass re-push owns the write port, so requests are refused in that cycle.
   assign req_ready_o = (!full || pop) && !bypass;
   assign push        = bypass || (req_valid_i && req_ready_o);
   assign push_data   = bypass ? head : req_t'{level: req_level_i, id: req_id_i};

   fractal_sync_req_ring #(
      .DEPTH   (DEPTH),
      .entry_t (req_t)
   ) u_ring (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count_o),
      .full      (full),
      .empty     (empty)
   );

   assign check_local_o  = check && head_local;
   assign check_remote_o = check && !head_local;
   assign level_o        = check ? head.level : '0;
   assign id_o           = check ? head.id    : '0;
   assign done_valid_o   = check && (verdict == VERD_PRESENT);
   assign done_level_o   = done_valid_o ? head.level : '0;
   assign done_id_o      = done_valid_o ? head.id    : '0;
   assign err_o          = check && (verdict == VERD_ERR);

endmodule

// File: tb/tb_fractal_sync_1d_req_queue.sv
// Directed bench for fractal_sync_1d_req_queue: a per-cycle vector table plus
// hand-written reset-flush and pointer-wrap sequences.
module tb_fractal_sync_1d_req_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = 2;
   localparam int unsigned IW    = 1;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [LW-1:0] req_level;
   logic [IW-1:0] req_id;
   logic [LW-1:0] level;
   logic [IW-1:0] id;
   logic          check_local;
   logic          check_remote;
   logic          present_local;
   logic          present_remote;
   logic          id_err;
   logic          sig_err;
   logic          bypass_local;
   logic          bypass_remote;
   logic          ignore_local;
   logic          ignore_remote;
   logic          done_valid;
   logic          done_ready;
   logic [LW-1:0] done_level;
   logic [IW-1:0] done_id;
   logic          err;
   logic [2:0]    count;

   int n_checks;
   int n_pass;

   fractal_sync_1d_req_queue #(
      .DEPTH       (DEPTH),
      .LEVEL_WIDTH (LW),
      .ID_WIDTH    (IW)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_level_i      (req_level),
      .req_id_i         (req_id),
      .level_o          (level),
      .id_o             (id),
      .check_local_o    (check_local),
      .check_remote_o   (check_remote),
      .present_local_i  (present_local),
      .present_remote_i (present_remote),
      .id_err_i         (id_err),
      .sig_err_i        (sig_err),
      .bypass_local_i   (bypass_local),
      .bypass_remote_i  (bypass_remote),
      .ignore_local_i   (ignore_local),
      .ignore_remote_i  (ignore_remote),
      .done_valid_o     (done_valid),
      .done_ready_i     (done_ready),
      .done_level_o     (done_level),
      .done_id_o        (done_id),
      .err_o            (err),
      .count_o          (count)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- vector table ----------------
   // rf bits: [7]present_local [6]present_remote [5]id_err [4]sig_err
   //          [3]bypass_local  [2]bypass_remote  [1]ignore_local [0]ignore_remote
   typedef struct {
      logic          v;
      logic [LW-1:0] lvl;
      logic [IW-1:0] rid;
      logic          dr;
      logic [7:0]    rf;
      logic          rdy;
      logic          cl;
      logic          cr;
      logic          dv;
      logic          er;
      logic [2:0]    cnt;
      logic [LW-1:0] olvl;
      logic [IW-1:0] oid;
      logic [LW-1:0] dlvl;
      logic [IW-1:0] did;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int v, input int lvl, input int rid, input int dr, input int rf,
                          input int rdy, input int cl, input int cr, input int dv, input int er,
                          input int cnt, input int olvl, input int oid, input int dlvl, input int did);
      vec_t t;
      t.v = 1'(v);       t.lvl = LW'(lvl);   t.rid = IW'(rid);  t.dr = 1'(dr);   t.rf = 8'(rf);
      t.rdy = 1'(rdy);   t.cl = 1'(cl);      t.cr = 1'(cr);     t.dv = 1'(dv);   t.er = 1'(er);
      t.cnt = 3'(cnt);   t.olvl = LW'(olvl); t.oid = IW'(oid);  t.dlvl = LW'(dlvl); t.did = IW'(did);
      vecs.push_back(t);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [LW-1:0] lvl, input logic [IW-1:0] rid,
                        input logic dr, input logic [7:0] rf);
      req_valid      = v;
      req_level      = lvl;
      req_id         = rid;
      done_ready     = dr;
      present_local  = rf[7];
      present_remote = rf[6];
      id_err         = rf[5];
      sig_err        = rf[4];
      bypass_local   = rf[3];
      bypass_remote  = rf[2];
      ignore_local   = rf[1];
      ignore_remote  = rf[0];
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // ---------------- scoreboard ----------------
   logic [LW+IW-1:0] exp_q[$];

   initial begin
      int sent;
      int recv;
      n_checks = 0;
      n_pass   = 0;
      drive(1'b0, '0, '0, 1'b0, 8'h00);
      rst = 1'b1;
      #22 rst = 1'b0;

      // v lvl id dr rf | rdy cl cr dv err cnt olvl oid dlvl did
      add_vec(1,0,1,1,'h00, 1,0,0,0,0,0,0,0,0,0);  // push (L0,1) into empty queue
      add_vec(0,0,0,1,'h80, 1,1,0,1,0,1,0,1,0,1);  // local present -> done
      add_vec(1,2,0,1,'h00, 1,0,0,0,0,0,0,0,0,0);  // push (L2,0)
      add_vec(0,0,0,1,'h00, 1,0,1,0,0,1,2,0,0,0);  // remote record
      add_vec(1,0,1,0,'h00, 1,0,0,0,0,0,0,0,0,0);  // push while stalled
      add_vec(0,0,0,0,'hA0, 1,0,0,0,0,1,0,0,0,0);  // stall: no check
      add_vec(0,0,0,1,'hA0, 1,1,0,0,1,1,0,1,0,0);  // id_err beats present
      add_vec(1,1,1,1,'h00, 1,0,0,0,0,0,0,0,0,0);  // push (L1,1)
      add_vec(0,0,0,1,'hAA, 1,0,1,0,0,1,1,1,0,0);  // local flags ignored on remote head
      add_vec(1,1,0,1,'h00, 1,0,0,0,0,0,0,0,0,0);  // push (L1,0)
      add_vec(0,0,0,1,'h41, 1,0,1,0,0,1,1,0,0,0);  // ignore beats present
      add_vec(1,0,0,1,'h00, 1,0,0,0,0,0,0,0,0,0);  // push (L0,0)
      add_vec(1,1,1,1,'h80, 1,1,0,1,0,1,0,0,0,0);  // enqueue + pop together
      add_vec(0,0,0,1,'h40, 1,0,1,1,0,1,1,1,1,1);  // remote present
      add_vec(1,0,0,0,'h00, 1,0,0,0,0,0,0,0,0,0);  // fill to 4
      add_vec(1,0,1,0,'h00, 1,0,0,0,0,1,0,0,0,0);
      add_vec(1,1,0,0,'h00, 1,0,0,0,0,2,0,0,0,0);
      add_vec(1,1,1,0,'h00, 1,0,0,0,0,3,0,0,0,0);
      add_vec(1,0,0,0,'h00, 0,0,0,0,0,4,0,0,0,0);  // full, no pop -> not ready
      add_vec(1,1,1,1,'h08, 0,1,0,0,0,4,0,0,0,0);  // bypass while full
      add_vec(1,1,1,1,'h80, 1,1,0,1,0,4,0,1,0,1);  // full + pop -> ready
      add_vec(0,0,0,1,'h04, 0,0,1,0,0,4,1,0,0,0);  // remote bypass
      add_vec(0,0,0,1,'h40, 1,0,1,1,0,4,1,1,1,1);
      add_vec(0,0,0,1,'h80, 1,1,0,1,0,3,0,0,0,0);  // recirculated entry now at head
      add_vec(0,0,0,1,'h10, 1,0,1,0,1,2,1,1,0,0);  // sig_err
      add_vec(0,0,0,1,'h04, 0,0,1,0,0,1,1,0,0,0);  // single-entry bypass loop
      add_vec(0,0,0,1,'h04, 0,0,1,0,0,1,1,0,0,0);
      add_vec(0,0,0,1,'h40, 1,0,1,1,0,1,1,0,1,0);
      add_vec(0,0,0,1,'hFF, 1,0,0,0,0,0,0,0,0,0);  // empty: flags have no effect

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         drive(vecs[i].v, vecs[i].lvl, vecs[i].rid, vecs[i].dr, vecs[i].rf);
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {req_ready, check_local, check_remote, done_valid, err, count, level, id, done_level, done_id},
               {vecs[i].rdy, vecs[i].cl, vecs[i].cr, vecs[i].dv, vecs[i].er, vecs[i].cnt,
                vecs[i].olvl, vecs[i].oid, vecs[i].dlvl, vecs[i].did});
      end

      // Reset mid-fill: three stalled entries are flushed without events.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         drive(1'b1, LW'(k), IW'(k), 1'b0, 8'h80);
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0, 8'h80);
      @(negedge clk);
      check("fill_count", 32'(count), 32'd3);
      #2 done_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_quiet", {check_local, check_remote, done_valid, err}, 4'b0000);
      @(posedge clk); #3 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("rst_empty", {check_local, check_remote, done_valid, 3'(count)}, 6'b000000);

      // Wrap: 10 requests through a 4-deep ring with periodic stalls.
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(posedge clk); #1;
         drive(sent < 10, LW'(sent % 3), IW'(sent % 2), (cyc % 4) != 3, 8'hC0);
         @(negedge clk);
         if (done_valid) begin
            if (exp_q.size() == 0) begin
               check("wrap_unexpected_done", {done_level, done_id}, '1);
            end else begin
               check($sformatf("wrap_done%0d", recv), {done_level, done_id}, exp_q.pop_front());
            end
            recv++;
         end
         if (req_valid && req_ready) begin
            exp_q.push_back({req_level, req_id});
            sent++;
         end
         if (sent == 10 && recv == 10) break;
      end
      check("wrap_recv", 32'(recv), 32'd10);
      drive(1'b0, '0, '0, 1'b1, 8'h00);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
